// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the fetch-stage PC sequencer.
//   - command encodings driven by the stage-0 controller on cmd
//   - default interrupt vector placement
//   - lowest-set-bit priority encoder used for interrupt channel selection
package proc_pkg;

  localparam logic [2:0] CMD_NEXT = 3'd0;
  localparam logic [2:0] CMD_JUMP = 3'd1;
  localparam logic [2:0] CMD_CALL = 3'd2;
  localparam logic [2:0] CMD_RET  = 3'd3;
  localparam logic [2:0] CMD_RETI = 3'd4;
  localparam logic [2:0] CMD_HOLD = 3'd5;

  localparam int unsigned VEC_BASE_DEF   = 32'hF0;
  localparam int unsigned VEC_STRIDE_DEF = 2;

  // Index of the lowest set bit; 0 when no bit is set (caller qualifies with |v).
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the stage-0 controller (master)
// and the PC sequencer (slave).
//   advance, cmd, target       - PC update request from stage 0
//   irq, irq_mask, irq_en      - interrupt lines, per-channel enables, global enable
//   pc                         - instruction-memory fetch address
//   irq_ack, irq_id, in_isr    - interrupt entry pulse, last taken channel, handler active
//   stack_level, stack_err     - return-stack occupancy and sticky fault flag
interface pc_sequencer_if #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NIRQ  = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic            advance;
  logic [2:0]      cmd;
  logic [AW-1:0]   target;
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] irq_mask;
  logic            irq_en;
  logic [AW-1:0]   pc;
  logic            irq_ack;
  logic [3:0]      irq_id;
  logic            in_isr;
  logic [LW-1:0]   stack_level;
  logic            stack_err;

  modport master (
    output advance, cmd, target, irq, irq_mask, irq_en,
    input  pc, irq_ack, irq_id, in_isr, stack_level, stack_err
  );

  modport slave (
    input  advance, cmd, target, irq, irq_mask, irq_en,
    output pc, irq_ack, irq_id, in_isr, stack_level, stack_err
  );

endinterface

// File: rtl/ret_stack.sv
// ret_stack: synchronous LIFO holding return addresses.
//   clk, clr            - clock, asynchronous active-low reset (level only; contents kept)
//   push, push_data     - write push_data on top; ignored when full
//   pop                 - discard top; ignored when empty
//   top                 - current top entry (undefined when empty)
//   level, full, empty  - occupancy
//   overflow, underflow - combinational: this cycle's push/pop was refused
// A pushed value is readable on top the cycle after the push, so push then pop
// returns it. Push takes priority if both are requested.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_dec;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    do_push   = push && !full;
    do_pop    = pop && !push && !empty;
    overflow  = push && full;
    underflow = pop && !push && empty;
    level_dec = level_q - 1'b1;
    wr_idx    = level_q[IW-1:0];
    rd_idx    = level_dec[IW-1:0];
  end

  // Storage is not reset: entries above level are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      level_q <= '0;
    end else if (do_push) begin
      level_q <= level_q + 1'b1;
    end else if (do_pop) begin
      level_q <= level_dec;
    end
  end

  assign top   = mem_q[rd_idx];
  assign level = level_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, return stack and vectored interrupt entry for the
// fetch stage.
//   clk  - system clock, rising edge
//   clr  - asynchronous active-low reset
//   bus  - pc_sequencer_if.slave: command/target/interrupt inputs, pc and status outputs
// Interrupts are edge-captured into pending bits; the lowest enabled pending channel
// is taken on an advance cycle when no handler is active and the stack has room.
// Taking an interrupt pushes the not-yet-executed pc and discards that cycle's cmd.
module pc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic           clk,
  input  logic           clr,
  pc_sequencer_if.slave  bus
);
  localparam int unsigned     LW      = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0]   ResetPc = AW'(RESET_PC);

  typedef enum logic [0:0] {StRun, StIsr} state_e;

  state_e          state_q;
  logic [AW-1:0]   pc_q;
  logic [NIRQ-1:0] pending_q;
  logic [NIRQ-1:0] prev_q;
  logic            irq_ack_q;
  logic [3:0]      irq_id_q;
  logic            stack_err_q;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] req;
  logic [NIRQ-1:0] take_mask;
  logic [NIRQ-1:0] pending_d;
  logic            take;
  logic [3:0]      take_id;
  logic [31:0]     vec_full;
  logic [AW-1:0]   vec_addr;
  logic [AW-1:0]   pc_inc;

  logic            stk_push;
  logic            stk_pop;
  logic [AW-1:0]   stk_push_data;
  logic [AW-1:0]   stk_top;
  logic [LW-1:0]   stk_level;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_overflow;
  logic            stk_underflow;

  ret_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ret_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_push_data),
    .top       (stk_top),
    .level     (stk_level),
    .full      (stk_full),
    .empty     (stk_empty),
    .overflow  (stk_overflow),
    .underflow (stk_underflow)
  );

  always_comb begin
    rise      = bus.irq & ~prev_q;
    req       = pending_q & bus.irq_mask;
    take      = bus.advance && bus.irq_en && (state_q == StRun) && (req != '0) && !stk_full;
    take_id   = lowest_set(16'(req));
    take_mask = take ? (NIRQ'(1) << take_id) : '0;
    // A new edge on the channel being taken re-arms it.
    pending_d = (pending_q & ~take_mask) | rise;
    pc_inc    = pc_q + AW'(1);
    vec_full  = VEC_BASE + 32'(take_id) * VEC_STRIDE;
    vec_addr  = vec_full[AW-1:0];

    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = pc_q;
    if (take) begin
      stk_push = 1'b1;
    end else if (bus.advance) begin
      case (bus.cmd)
        CMD_CALL: begin
          stk_push      = 1'b1;
          stk_push_data = pc_inc;
        end
        CMD_RET, CMD_RETI: stk_pop = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StRun;
      pc_q        <= ResetPc;
      pending_q   <= '0;
      prev_q      <= '1;  // a line already high at reset release is not an edge
      irq_ack_q   <= 1'b0;
      irq_id_q    <= '0;
      stack_err_q <= 1'b0;
    end else begin
      prev_q    <= bus.irq;
      pending_q <= pending_d;
      irq_ack_q <= take;
      if (stk_overflow || stk_underflow) stack_err_q <= 1'b1;

      if (take) begin
        pc_q     <= vec_addr;
        irq_id_q <= take_id;
        state_q  <= StIsr;
      end else if (bus.advance) begin
        case (bus.cmd)
          CMD_NEXT:           pc_q <= pc_inc;
          CMD_JUMP, CMD_CALL: pc_q <= bus.target;  // CALL jumps even if the push is refused
          CMD_RET: begin
            if (!stk_empty) pc_q <= stk_top;
          end
          CMD_RETI: begin
            if (!stk_empty) pc_q <= stk_top;
            state_q <= StRun;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.in_isr      = (state_q == StIsr);
  assign bus.stack_level = stk_level;
  assign bus.stack_err   = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a scoreboard queue of expected
// output values, pushed as each step is driven and popped after the following edge.
module tb_pc_sequencer;
  import proc_pkg::*;

  localparam int SelPc    = 0;
  localparam int SelLevel = 1;
  localparam int SelErr   = 2;
  localparam int SelIsr   = 3;
  localparam int SelAck   = 4;
  localparam int SelId    = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic clr;
  exp_t sb[$];
  int   checks;
  int   passes;
  int   fails;

  pc_sequencer_if #(.AW(8), .DEPTH(4), .NIRQ(4)) bus ();

  pc_sequencer #(
    .AW         (8),
    .DEPTH      (4),
    .NIRQ       (4),
    .RESET_PC   (0),
    .VEC_BASE   (32'hF0),
    .VEC_STRIDE (2)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelPc:    return 32'(bus.pc);
      SelLevel: return 32'(bus.stack_level);
      SelErr:   return 32'(bus.stack_err);
      SelIsr:   return 32'(bus.in_isr);
      SelAck:   return 32'(bus.irq_ack);
      SelId:    return 32'(bus.irq_id);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) passes++;
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic drive(input logic adv, input logic [2:0] c, input logic [7:0] t);
    bus.advance = adv;
    bus.cmd     = c;
    bus.target  = t;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_val({tag, "_pc"}, SelPc, 0);
    expect_val({tag, "_level"}, SelLevel, 0);
    expect_val({tag, "_err"}, SelErr, 0);
    expect_val({tag, "_isr"}, SelIsr, 0);
    expect_val({tag, "_ack"}, SelAck, 0);
    expect_val({tag, "_id"}, SelId, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges; checks land before any edge.
  task automatic async_reset(input string tag);
    #2 clr = 1'b0;
    #1;
    expect_reset_state(tag);
    drain();
    #1 clr = 1'b1;
  endtask

  initial begin
    logic [7:0] call_tgt[4];
    logic [7:0] ret_pc[4];
    checks = 0;
    passes = 0;
    fails  = 0;

    // Reset with irq[0] already high: must never count as an edge.
    clr          = 1'b0;
    drive(1'b0, CMD_NEXT, 8'h00);
    bus.irq      = 4'b0001;
    bus.irq_mask = 4'b1111;
    bus.irq_en   = 1'b1;
    #3;
    expect_reset_state("reset");
    drain();
    #4 clr = 1'b1;

    // Sequential fetch with wrap.
    drive(1'b1, CMD_NEXT, 8'h00);
    for (int k = 1; k <= 300; k++) begin
      expect_val("seq_pc", SelPc, 32'(k % 256));
      cycle();
    end
    expect_val("level_irq_isr", SelIsr, 0);
    expect_val("level_irq_ack", SelAck, 0);
    drain();
    bus.irq = 4'b0000;

    // Freeze: advance low, HOLD, and unused codes 6/7.
    drive(1'b0, CMD_NEXT, 8'h00);
    for (int k = 0; k < 3; k++) begin
      expect_val("noadv_pc", SelPc, 44);
      cycle();
    end
    drive(1'b1, CMD_HOLD, 8'h00);
    expect_val("hold_pc", SelPc, 44);
    cycle();
    drive(1'b1, 3'd6, 8'h77);
    expect_val("cmd6_pc", SelPc, 44);
    cycle();
    drive(1'b1, 3'd7, 8'h77);
    expect_val("cmd7_pc", SelPc, 44);
    cycle();

    // Call / return.
    drive(1'b1, CMD_JUMP, 8'h10);
    expect_val("jump_pc", SelPc, 8'h10);
    cycle();
    drive(1'b1, CMD_CALL, 8'h40);
    expect_val("call_pc", SelPc, 8'h40);
    expect_val("call_level", SelLevel, 1);
    cycle();
    drive(1'b1, CMD_RET, 8'h00);
    expect_val("ret_pc", SelPc, 8'h11);
    expect_val("ret_level", SelLevel, 0);
    expect_val("ret_err", SelErr, 0);
    cycle();

    // Nested calls to overflow, then unwind.
    call_tgt[0] = 8'h50; call_tgt[1] = 8'h60; call_tgt[2] = 8'h70; call_tgt[3] = 8'h80;
    ret_pc[0]   = 8'h71; ret_pc[1]   = 8'h61; ret_pc[2]   = 8'h51; ret_pc[3]   = 8'h12;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, CMD_CALL, call_tgt[k]);
      expect_val("nest_pc", SelPc, 32'(call_tgt[k]));
      expect_val("nest_level", SelLevel, 32'(k + 1));
      expect_val("nest_err", SelErr, 0);
      cycle();
    end
    drive(1'b1, CMD_CALL, 8'h90);
    expect_val("ovf_pc", SelPc, 8'h90);
    expect_val("ovf_level", SelLevel, 4);
    expect_val("ovf_err", SelErr, 1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, CMD_RET, 8'h00);
      expect_val("unwind_pc", SelPc, 32'(ret_pc[k]));
      expect_val("unwind_level", SelLevel, 32'(3 - k));
      cycle();
    end

    // Underflow right after reset.
    async_reset("rst1");
    drive(1'b1, CMD_RET, 8'h00);
    expect_val("unf_pc", SelPc, 0);
    expect_val("unf_level", SelLevel, 0);
    expect_val("unf_err", SelErr, 1);
    cycle();

    // Vectoring: channels 1 and 2 rise together.
    async_reset("rst2");
    drive(1'b1, CMD_JUMP, 8'h20);
    expect_val("vjump_pc", SelPc, 8'h20);
    cycle();
    drive(1'b1, CMD_HOLD, 8'h00);
    bus.irq = 4'b0110;
    expect_val("cap_pc", SelPc, 8'h20);
    expect_val("cap_ack", SelAck, 0);
    cycle();
    expect_val("vec1_pc", SelPc, 8'hF2);
    expect_val("vec1_id", SelId, 1);
    expect_val("vec1_ack", SelAck, 1);
    expect_val("vec1_isr", SelIsr, 1);
    expect_val("vec1_level", SelLevel, 1);
    cycle();
    expect_val("ack_drop", SelAck, 0);
    expect_val("nest_lock_pc", SelPc, 8'hF2);
    cycle();
    drive(1'b1, CMD_RETI, 8'h00);
    expect_val("reti1_pc", SelPc, 8'h20);
    expect_val("reti1_isr", SelIsr, 0);
    expect_val("reti1_level", SelLevel, 0);
    cycle();
    drive(1'b1, CMD_NEXT, 8'h00);
    expect_val("vec2_pc", SelPc, 8'hF4);
    expect_val("vec2_id", SelId, 2);
    expect_val("vec2_ack", SelAck, 1);
    cycle();
    drive(1'b1, CMD_RETI, 8'h00);
    expect_val("reti2_pc", SelPc, 8'h20);
    expect_val("reti2_isr", SelIsr, 0);
    cycle();

    // Masking: channel 3 waits 100 cycles while masked.
    bus.irq_mask = 4'b0111;
    bus.irq      = 4'b1110;
    drive(1'b1, CMD_NEXT, 8'h00);
    for (int k = 1; k <= 100; k++) begin
      expect_val("masked_pc", SelPc, 32'((8'h20 + k) % 256));
      expect_val("masked_isr", SelIsr, 0);
      cycle();
    end
    bus.irq_mask = 4'b1111;
    drive(1'b1, CMD_HOLD, 8'h00);
    expect_val("unmask_pc", SelPc, 8'hF6);
    expect_val("unmask_id", SelId, 3);
    expect_val("unmask_ack", SelAck, 1);
    cycle();

    // Channel 0 edge during the handler is held until after RETI.
    bus.irq = 4'b1111;
    expect_val("lock_pc", SelPc, 8'hF6);
    expect_val("lock_ack", SelAck, 0);
    cycle();
    expect_val("lock2_pc", SelPc, 8'hF6);
    expect_val("lock2_isr", SelIsr, 1);
    cycle();
    drive(1'b1, CMD_RETI, 8'h00);
    expect_val("reti3_pc", SelPc, 8'h84);
    expect_val("reti3_isr", SelIsr, 0);
    expect_val("reti3_ack", SelAck, 0);
    cycle();
    drive(1'b1, CMD_HOLD, 8'h00);
    expect_val("vec0_pc", SelPc, 8'hF0);
    expect_val("vec0_id", SelId, 0);
    expect_val("vec0_ack", SelAck, 1);
    cycle();
    drive(1'b1, CMD_RETI, 8'h00);
    expect_val("reti4_pc", SelPc, 8'h84);
    expect_val("reti4_isr", SelIsr, 0);
    cycle();

    // Async reset mid-ISR with three stack entries.
    bus.irq_en = 1'b0;
    bus.irq    = 4'b1011;
    drive(1'b1, CMD_CALL, 8'h30);
    expect_val("pre_call1_pc", SelPc, 8'h30);
    cycle();
    bus.irq = 4'b1111;
    drive(1'b1, CMD_CALL, 8'h38);
    expect_val("pre_call2_level", SelLevel, 2);
    cycle();
    bus.irq_en = 1'b1;
    drive(1'b1, CMD_HOLD, 8'h00);
    expect_val("deep_pc", SelPc, 8'hF4);
    expect_val("deep_level", SelLevel, 3);
    expect_val("deep_id", SelId, 2);
    expect_val("deep_ack", SelAck, 1);
    cycle();
    async_reset("rst_isr");

    // Lines high across reset release: no take afterwards.
    drive(1'b1, CMD_NEXT, 8'h00);
    expect_val("post_rst_pc", SelPc, 1);
    expect_val("post_rst_isr", SelIsr, 0);
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
